// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM stage with built-in MEM/WB register.
// ALU results pass straight to writeback one cycle later.
// Loads and stores go out over a req/ack data-memory port.
// Byte lanes are steered little-endian, and loads are sign- or zero-extended.
// The upstream stage is stalled until the memory access completes.
// Optional bus timeout: set TIMEOUT_CYC > 0.
// Optional alignment exception: define MEM_ALIGN_EXC_EN. With it, misaligned
// accesses are rejected with misalign_o. Without it, the address is aligned down.
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter int REG_AW      = 5,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [3:0]        mem_op_i,
  input  logic [REG_AW-1:0] wreg_addr_i,
  input  logic              wreg_enable_i,
  input  logic [31:0]       wdata_i,
  input  logic [31:0]       store_data_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [REG_AW-1:0] wreg_addr_o,
  output logic              wreg_enable_o,
  output logic [31:0]       wdata_o,
  output logic              bus_err_o
`ifdef MEM_ALIGN_EXC_EN
  ,
  output logic              misalign_o
`endif
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t state_reg, state_next;

  // Captured memory request, held stable for the whole BUSY phase
  logic [3:0]        op_reg;
  logic [1:0]        lane_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [3:0]        be_reg;
  logic [31:0]       sdata_reg;
  logic              we_reg;
  logic [REG_AW-1:0] dest_reg;
  logic              dest_en_reg;

  // MEM/WB register
  logic              wb_valid_reg, wb_valid_next;
  logic [REG_AW-1:0] wb_addr_reg, wb_addr_next;
  logic              wb_en_reg, wb_en_next;
  logic [31:0]       wb_data_reg, wb_data_next;
  logic              bus_err_reg, bus_err_next;

  logic              capture_en;
  logic              timeout_hit;
  logic              align_exc;

  // Incoming instruction decode
  logic              is_mem, is_store;
  logic [3:0]        be_calc;
  logic [31:0]       sdata_calc;
  logic [ADDR_W-1:0] ea;

  // The effective address comes from the 32-bit ALU result, resized to ADDR_W
  generate
    if (ADDR_W <= 32) begin : g_ea_trunc
      assign ea = wdata_i[ADDR_W-1:0];
    end else begin : g_ea_ext
      assign ea = {{(ADDR_W-32){1'b0}}, wdata_i};
    end
  endgenerate

`ifdef MEM_ALIGN_EXC_EN
  // Halfword accesses need a[0]=0; word accesses need a[1:0]=0
  assign align_exc = (((mem_op_i == OP_LH) || (mem_op_i == OP_LHU) || (mem_op_i == OP_SH)) && ea[0]) ||
                     (((mem_op_i == OP_LW) || (mem_op_i == OP_SW)) && (ea[1:0] != 2'b00));
`else
  assign align_exc = 1'b0;
`endif

  // Decode the op, the byte enables and the replicated store data
  always_comb begin
    is_mem     = (mem_op_i >= OP_LB) && (mem_op_i <= OP_SW);
    is_store   = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    be_calc    = 4'b1111;
    sdata_calc = store_data_i;
    case (mem_op_i)
      OP_LB, OP_LBU, OP_SB: begin
        be_calc    = 4'b0001 << ea[1:0];
        sdata_calc = {4{store_data_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        be_calc    = ea[1] ? 4'b1100 : 4'b0011;
        sdata_calc = {2{store_data_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        sdata_calc = store_data_i;
      end
    endcase
  end

  // Select the addressed lane of the load word and extend it
  function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Bus timeout counter. It is held clear in IDLE, so it starts at zero on BUSY entry.
  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT_CYC + 1);
      logic [CW-1:0] cnt_reg;
      // Count the BUSY cycles of the current access
      always_ff @(posedge clk) begin
        if (rst || (state_reg == S_IDLE)) cnt_reg <= '0;
        else                              cnt_reg <= cnt_reg + 1'b1;
      end
      assign timeout_hit = (state_reg == S_BUSY) && (cnt_reg == CW'(TIMEOUT_CYC - 1)) && !dmem_ack_i;
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state, stall and writeback selection
  always_comb begin
    state_next    = state_reg;
    capture_en    = 1'b0;
    stall_o       = 1'b0;
    wb_valid_next = 1'b0;
    wb_addr_next  = wb_addr_reg;
    wb_en_next    = 1'b0;
    wb_data_next  = wb_data_reg;
    bus_err_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (!is_mem) begin
            wb_valid_next = 1'b1;
            wb_addr_next  = wreg_addr_i;
            wb_en_next    = wreg_enable_i;
            wb_data_next  = wdata_i;
          end else if (align_exc) begin
            wb_valid_next = 1'b1;
            wb_addr_next  = wreg_addr_i;
            wb_data_next  = 32'd0;
          end else begin
            stall_o    = 1'b1;
            capture_en = 1'b1;
            state_next = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ack_i) begin
          wb_valid_next = 1'b1;
          wb_addr_next  = dest_reg;
          wb_en_next    = !we_reg && dest_en_reg;
          wb_data_next  = we_reg ? 32'd0 : fmt_load(op_reg, lane_reg, dmem_rdata_i);
          state_next    = S_IDLE;
        end else if (timeout_hit) begin
          // The last BUSY cycle releases the pipeline and completes with an error
          wb_valid_next = 1'b1;
          wb_addr_next  = dest_reg;
          wb_data_next  = 32'd0;
          bus_err_next  = 1'b1;
          state_next    = S_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) stall_o = 1'b0;
  end

  // Latch the request when entering BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= 4'd0;
      lane_reg    <= 2'd0;
      addr_reg    <= '0;
      be_reg      <= 4'd0;
      sdata_reg   <= 32'd0;
      we_reg      <= 1'b0;
      dest_reg    <= '0;
      dest_en_reg <= 1'b0;
    end else if (capture_en) begin
      op_reg      <= mem_op_i;
      lane_reg    <= ea[1:0];
      addr_reg    <= {ea[ADDR_W-1:2], 2'b00};
      be_reg      <= be_calc;
      sdata_reg   <= sdata_calc;
      we_reg      <= is_store;
      dest_reg    <= wreg_addr_i;
      dest_en_reg <= wreg_enable_i;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_addr_reg  <= '0;
      wb_en_reg    <= 1'b0;
      wb_data_reg  <= 32'd0;
      bus_err_reg  <= 1'b0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      wb_addr_reg  <= wb_addr_next;
      wb_en_reg    <= wb_en_next;
      wb_data_reg  <= wb_data_next;
      bus_err_reg  <= bus_err_next;
    end
  end

`ifdef MEM_ALIGN_EXC_EN
  logic misalign_reg;
  // Flag a rejected misaligned access for one cycle, together with its writeback slot
  always_ff @(posedge clk) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= (state_reg == S_IDLE) && ex_valid_i && is_mem && align_exc;
  end
  assign misalign_o = misalign_reg;
`endif

  assign dmem_req_o    = (state_reg == S_BUSY);
  assign dmem_we_o     = dmem_req_o && we_reg;
  assign dmem_addr_o   = dmem_req_o ? addr_reg : '0;
  assign dmem_be_o     = dmem_req_o ? be_reg : 4'd0;
  assign dmem_wdata_o  = dmem_req_o ? sdata_reg : 32'd0;
  assign wb_valid_o    = wb_valid_reg;
  assign wreg_addr_o   = wb_addr_reg;
  assign wreg_enable_o = wb_en_reg;
  assign wdata_o       = wb_data_reg;
  assign bus_err_o     = bus_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (TIMEOUT_CYC = 4).
// Expected values come from a behavioural model of access size, lane and extension.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [3:0]  mem_op_i;
  logic [4:0]  wreg_addr_i;
  logic        wreg_enable_i;
  logic [31:0] wdata_i, store_data_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wreg_addr_o;
  logic        wreg_enable_o;
  logic [31:0] wdata_o;
  logic        bus_err_o;
`ifdef MEM_ALIGN_EXC_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .REG_AW(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .mem_op_i(mem_op_i),
    .wreg_addr_i(wreg_addr_i), .wreg_enable_i(wreg_enable_i), .wdata_i(wdata_i),
    .store_data_i(store_data_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wreg_addr_o(wreg_addr_o), .wreg_enable_o(wreg_enable_o),
    .wdata_o(wdata_o), .bus_err_o(bus_err_o)
`ifdef MEM_ALIGN_EXC_EN
    , .misalign_o(misalign_o)
`endif
  );

  typedef struct {
    int          stall_cnt;
    int          req_cnt;
    int          ncyc;
    logic        done;
    logic        held;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [4:0]  wba;
    logic        wben;
    logic [31:0] wbd;
    logic        err;
  } obs_t;

  // ---------------- behavioural reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic int m_lane(input logic [3:0] op, input logic [31:0] a);
    int sz = op_size(op);
    if (sz == 1) return int'(a % 4);
    if (sz == 2) return int'((a % 4) / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int sz = op_size(op);
    return 4'(((1 << sz) - 1) << m_lane(op, a));
  endfunction

  function automatic logic [31:0] m_sdata(input logic [3:0] op, input logic [31:0] sd);
    int sz = op_size(op);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (rd >> (8 * m_lane(op, a))) & mask;
    if (((op == 4'd1) || (op == 4'd3)) && (((v >> (8 * sz - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  // Issues one instruction and plays the memory with an ack after ack_delay BUSY cycles (-1 = never).
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] dest, input logic en, input logic [31:0] rdata,
                         input int ack_delay, output obs_t o);
    o = '{default: 0};
    o.held = 1'b1;
    @(negedge clk);
    ex_valid_i = 1'b1; mem_op_i = op; wdata_i = addr; store_data_i = sd;
    wreg_addr_i = dest; wreg_enable_i = en; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    #1;
    if (stall_o) o.stall_cnt++;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      o.ncyc++;
      dmem_ack_i = 1'b0;
      if (wb_valid_o) begin
        o.done = 1'b1; o.wba = wreg_addr_o; o.wben = wreg_enable_o; o.wbd = wdata_o; o.err = bus_err_o;
        ex_valid_i = 1'b0; mem_op_i = 4'd0;
        break;
      end
      if (dmem_req_o) begin
        if (o.req_cnt == 0) begin
          o.addr = dmem_addr_o; o.be = dmem_be_o; o.wd = dmem_wdata_o; o.we = dmem_we_o;
        end else if (o.addr !== dmem_addr_o || o.be !== dmem_be_o || o.wd !== dmem_wdata_o || o.we !== dmem_we_o) begin
          o.held = 1'b0;
        end
        o.req_cnt++;
        if (o.req_cnt - 1 == ack_delay) begin
          dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
        end
      end
      #1;
      if (stall_o) o.stall_cnt++;
    end
    if (!o.done) begin
      ex_valid_i = 1'b0; dmem_ack_i = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ex_valid_i = 1'b1; mem_op_i = 4'd5; wdata_i = 32'h100; store_data_i = 32'd0;
    wreg_addr_i = 5'd1; wreg_enable_i = 1'b1; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    n_checks++; if (dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", dmem_req_o); end
    n_checks++; if ({dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o} !== 69'd0) begin n_fail++; $display("FAIL reset_dmem got %h want 0", {dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o}); end
    n_checks++; if ({wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, bus_err_o} !== 40'd0) begin n_fail++; $display("FAIL reset_wb got %h want 0", {wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, bus_err_o}); end
    ex_valid_i = 1'b0; mem_op_i = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    // An ack while IDLE must be ignored
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    n_checks++; if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_ack got wbv=%0b req=%0b want 0 0", wb_valid_o, dmem_req_o); end
    $display("reset: done");
  endtask

  task automatic test_passthrough();
    obs_t o;
    run_mem(4'd0, 32'h1234, 32'd0, 5'd5, 1'b1, 32'd0, 0, o);
    n_checks++; if (o.done !== 1'b1 || o.ncyc != 1) begin n_fail++; $display("FAIL pass_latency got done=%0b ncyc=%0d want 1 1", o.done, o.ncyc); end
    n_checks++; if (o.wba !== 5'd5 || o.wbd !== 32'h1234 || o.wben !== 1'b1) begin n_fail++; $display("FAIL pass_wb got r%0d=%h en=%0b want r5=1234 en=1", o.wba, o.wbd, o.wben); end
    n_checks++; if (o.stall_cnt != 0 || o.req_cnt != 0) begin n_fail++; $display("FAIL pass_stall got stall=%0d req=%0d want 0 0", o.stall_cnt, o.req_cnt); end
    $display("passthrough: r%0d <= %h", o.wba, o.wbd);
  endtask

  task automatic test_lb();
    obs_t o;
    run_mem(4'd1, 32'h103, 32'd0, 5'd9, 1'b1, 32'h80FF_FF00, 3, o);
    n_checks++; if (o.be !== 4'b1000 || o.addr !== 32'h100 || o.we !== 1'b0) begin n_fail++; $display("FAIL lb_req got be=%b addr=%h we=%0b want 1000 100 0", o.be, o.addr, o.we); end
    n_checks++; if (o.wbd !== 32'hFFFF_FF80 || o.wben !== 1'b1 || o.wba !== 5'd9) begin n_fail++; $display("FAIL lb_data got r%0d=%h en=%0b want r9=ffffff80 en=1", o.wba, o.wbd, o.wben); end
    n_checks++; if (o.stall_cnt != 4 || o.req_cnt != 4 || !o.held) begin n_fail++; $display("FAIL lb_stall got stall=%0d req=%0d held=%0b want 4 4 1", o.stall_cnt, o.req_cnt, o.held); end
    $display("lb: wdata_o=%h stall=%0d", o.wbd, o.stall_cnt);
  endtask

  task automatic test_sh();
    obs_t o;
    run_mem(4'd7, 32'h102, 32'h0000_ABCD, 5'd3, 1'b1, 32'd0, 0, o);
    n_checks++; if (o.be !== 4'b1100 || o.wd !== 32'hABCD_ABCD || o.we !== 1'b1) begin n_fail++; $display("FAIL sh_req got be=%b wd=%h we=%0b want 1100 abcdabcd 1", o.be, o.wd, o.we); end
    n_checks++; if (o.done !== 1'b1 || o.wben !== 1'b0 || o.ncyc != 2) begin n_fail++; $display("FAIL sh_wb got done=%0b en=%0b ncyc=%0d want 1 0 2", o.done, o.wben, o.ncyc); end
    $display("sh: be=%b wdata=%h", o.be, o.wd);
  endtask

  task automatic test_timeout();
    obs_t o;
    run_mem(4'd5, 32'h400, 32'd0, 5'd12, 1'b1, 32'h1111_2222, -1, o);
    n_checks++; if (o.req_cnt != 4 || o.stall_cnt != 4) begin n_fail++; $display("FAIL to_cycles got req=%0d stall=%0d want 4 4", o.req_cnt, o.stall_cnt); end
    n_checks++; if (o.done !== 1'b1 || o.err !== 1'b1 || o.wben !== 1'b0 || o.wbd !== 32'd0) begin n_fail++; $display("FAIL to_wb got done=%0b err=%0b en=%0b d=%h want 1 1 0 0", o.done, o.err, o.wben, o.wbd); end
    @(negedge clk);
    n_checks++; if (bus_err_o !== 1'b0 || dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL to_pulse got err=%0b req=%0b wbv=%0b want 0 0 0", bus_err_o, dmem_req_o, wb_valid_o); end
    run_mem(4'd5, 32'h404, 32'd0, 5'd13, 1'b1, 32'h3333_4444, 3, o);
    n_checks++; if (o.err !== 1'b0 || o.wben !== 1'b1 || o.wbd !== 32'h3333_4444 || o.req_cnt != 4) begin n_fail++; $display("FAIL to_ack_wins got err=%0b en=%0b d=%h req=%0d want 0 1 33334444 4", o.err, o.wben, o.wbd, o.req_cnt); end
    $display("timeout: checked never-ack and ack-in-last-cycle");
  endtask

  task automatic test_rst_busy();
    @(negedge clk);
    ex_valid_i = 1'b1; mem_op_i = 4'd5; wdata_i = 32'h200; wreg_addr_i = 5'd7; wreg_enable_i = 1'b1;
    @(negedge clk);
    n_checks++; if (dmem_req_o !== 1'b1) begin n_fail++; $display("FAIL rstb_req_on got %0b want 1", dmem_req_o); end
    ex_valid_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++; if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstb_req_off got req=%0b wbv=%0b want 0 0", dmem_req_o, wb_valid_o); end
    rst = 1'b0; dmem_ack_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    dmem_ack_i = 1'b0;
    n_checks++; if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstb_late_ack got req=%0b wbv=%0b want 0 0", dmem_req_o, wb_valid_o); end
    $display("rst_busy: request dropped");
  endtask

  task automatic test_misalign();
    obs_t o;
    run_mem(4'd5, 32'h101, 32'd0, 5'd4, 1'b1, 32'hCAFE_F00D, 0, o);
`ifdef MEM_ALIGN_EXC_EN
    n_checks++; if (o.req_cnt != 0 || o.ncyc != 1 || o.wben !== 1'b0 || misalign_o !== 1'b1) begin n_fail++; $display("FAIL misalign_exc got req=%0d ncyc=%0d en=%0b mis=%0b want 0 1 0 1", o.req_cnt, o.ncyc, o.wben, misalign_o); end
    @(negedge clk);
    n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse got %0b want 0", misalign_o); end
`else
    n_checks++; if (o.addr !== 32'h100 || o.be !== 4'b1111 || o.req_cnt != 1) begin n_fail++; $display("FAIL misalign_addr got addr=%h be=%b req=%0d want 100 1111 1", o.addr, o.be, o.req_cnt); end
    n_checks++; if (o.wbd !== 32'hCAFE_F00D || o.wben !== 1'b1) begin n_fail++; $display("FAIL misalign_load got d=%h en=%0b want cafef00d 1", o.wbd, o.wben); end
`endif
    $display("misalign: LW 0x101 done");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        pe, pv;
    pa = 5'd0; pd = 32'd0; pe = 1'b0; pv = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (wb_valid_o !== pv || wreg_enable_o !== pe || (pv && (wreg_addr_o !== pa || wdata_o !== pd))) begin
          n_fail++;
          $display("FAIL b2b_%0d got v=%0b en=%0b r%0d=%h want v=%0b en=%0b r%0d=%h", i, wb_valid_o, wreg_enable_o, wreg_addr_o, wdata_o, pv, pe, pa, pd);
        end
        n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_%0d got %0b want 0", i, stall_o); end
      end
      if (i == 8) begin
        ex_valid_i = 1'b0;
      end else begin
        pv = (i != 4);
        pa = 5'($urandom_range(0, 31)); pd = $urandom; pe = 1'($urandom_range(0, 1));
        ex_valid_i = pv; mem_op_i = 4'($urandom_range(9, 15)) & {4{i[0]}};
        wreg_addr_i = pa; wdata_i = pd; wreg_enable_i = pe;
        if (!pv) pe = 1'b0;
      end
      $display("b2b: slot %0d", i);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [3:0]  op;
    logic [31:0] a, sd, rd;
    logic [4:0]  dst;
    logic        en;
    int          d, sz;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15)); a = $urandom; sd = $urandom; rd = $urandom;
      dst = 5'($urandom_range(0, 31)); en = 1'($urandom_range(0, 1)); d = $urandom_range(0, 3);
      sz = op_size(op);
`ifdef MEM_ALIGN_EXC_EN
      if (sz > 0) a = a & ~32'(sz - 1);
`endif
      run_mem(op, a, sd, dst, en, rd, d, o);
      if (sz == 0) begin
        n_checks++;
        if (o.done !== 1'b1 || o.ncyc != 1 || o.req_cnt != 0 || o.stall_cnt != 0 || o.wba !== dst || o.wben !== en || o.wbd !== a) begin
          n_fail++;
          $display("FAIL rand_alu_%0d op=%0d got ncyc=%0d req=%0d r%0d=%h en=%0b want 1 0 r%0d=%h en=%0b", i, op, o.ncyc, o.req_cnt, o.wba, o.wbd, o.wben, dst, a, en);
        end
      end else begin
        n_checks++;
        if (o.req_cnt != d + 1 || o.stall_cnt != d + 1 || o.ncyc != d + 2 || !o.held) begin
          n_fail++;
          $display("FAIL rand_timing_%0d op=%0d got req=%0d stall=%0d ncyc=%0d held=%0b want %0d %0d %0d 1", i, op, o.req_cnt, o.stall_cnt, o.ncyc, o.held, d + 1, d + 1, d + 2);
        end
        n_checks++;
        if (o.addr !== (a & ~32'd3) || o.be !== m_be(op, a) || o.we !== op_store(op) || (op_store(op) && o.wd !== m_sdata(op, sd))) begin
          n_fail++;
          $display("FAIL rand_bus_%0d op=%0d a=%h got addr=%h be=%b we=%0b wd=%h want %h %b %0b %h", i, op, a, o.addr, o.be, o.we, o.wd, a & ~32'd3, m_be(op, a), op_store(op), m_sdata(op, sd));
        end
        n_checks++;
        if (o.wba !== dst || o.err !== 1'b0 || o.wben !== (en && !op_store(op)) || (!op_store(op) && o.wbd !== m_load(op, a, rd))) begin
          n_fail++;
          $display("FAIL rand_wb_%0d op=%0d a=%h rd=%h got r%0d=%h en=%0b err=%0b want r%0d=%h en=%0b", i, op, a, rd, o.wba, o.wbd, o.wben, o.err, dst, m_load(op, a, rd), en && !op_store(op));
        end
      end
      $display("rand %0d: op=%0d addr=%h ack_delay=%0d wb=%h", i, op, a, d, o.wbd);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_lb();
    test_sh();
    test_timeout();
    test_rst_busy();
    test_misalign();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
